// File: rtl/ex_div.sv
// ex_div: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// A launch from IDLE latches the operands. A divide-by-zero or a signed
// overflow resolves in one cycle. Any other launch runs DATA_W shift/subtract
// steps in CALC, then the sign fix-up in END.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   startIn       launch request, sampled only in IDLE
//   opIn          funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividendIn    rs1 value
//   divisorIn     rs2 value
//   wAddrIn       destination register
//   flushIn       abort (jump); overrides startIn in IDLE
//   resultOut     quotient or remainder, held until the next completion
//   readyOut      one-cycle result-valid pulse
//   wAddrOut      destination register of the completed result
//   busyOut       high while state != IDLE
//   holdOut       combinational stall request to Ctrl
//
// state  | meaning
// IDLE   | waiting for startIn; special cases complete from here
// CALC   | one restoring step per cycle, DATA_W cycles
// END    | sign fix-up, result registered, back to IDLE
module ex_div #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startIn,
  input  logic [1:0]        opIn,
  input  logic [DATA_W-1:0] dividendIn,
  input  logic [DATA_W-1:0] divisorIn,
  input  logic [4:0]        wAddrIn,
  input  logic              flushIn,
  output logic [DATA_W-1:0] resultOut,
  output logic              readyOut,
  output logic [4:0]        wAddrOut,
  output logic              busyOut,
  output logic              holdOut
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_END = 2'd2} state_t;

  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            stateQ, stateD;
  logic [DATA_W-1:0] divisorQ, remQ, quotQ;
  logic [CNT_W-1:0]  cntQ;
  logic [4:0]        wAddrQ;
  logic              isRemQ, negQuotQ, negRemQ;

  logic              signedOp, divZero, overflow, special, launch, lastStep;
  logic [DATA_W-1:0] absDividend, absDivisor, specialResult, finalResult;
  logic [DATA_W:0]   remShift, remDiff;
  logic              remGe;

  assign signedOp    = ~opIn[0];
  assign absDividend = (signedOp && dividendIn[DATA_W-1]) ? -dividendIn : dividendIn;
  assign absDivisor  = (signedOp && divisorIn[DATA_W-1])  ? -divisorIn  : divisorIn;
  assign divZero     = (divisorIn == '0);
  assign overflow    = signedOp && (dividendIn == MIN_NEG) && (divisorIn == '1);
  assign special     = divZero || overflow;
  assign launch      = (stateQ == S_IDLE) && startIn && !flushIn;
  assign lastStep    = (cntQ == CNT_W'(DATA_W-1));

  always_comb begin
    specialResult = '0;
    if (divZero) specialResult = opIn[1] ? dividendIn : '1;
    else         specialResult = opIn[1] ? '0 : MIN_NEG;
  end

  // The remainder stays below the divisor, so the shifted value fits in
  // DATA_W+1 bits; the borrow out of that subtraction decides the step.
  assign remShift = {remQ, quotQ[DATA_W-1]};
  assign remDiff  = remShift - {1'b0, divisorQ};
  assign remGe    = ~remDiff[DATA_W];

  assign finalResult = isRemQ ? (negRemQ  ? -remQ  : remQ)
                              : (negQuotQ ? -quotQ : quotQ);

  // state register
  always_ff @(posedge clk) begin
    if (rst) stateQ <= S_IDLE;
    else     stateQ <= stateD;
  end

  // next state
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      S_IDLE:  if (launch && !special) stateD = S_CALC;
      S_CALC:  if (flushIn) stateD = S_IDLE;
               else if (lastStep) stateD = S_END;
      S_END:   stateD = S_IDLE;
      default: stateD = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busyOut = (stateQ != S_IDLE);
    holdOut = (launch && !special) || (stateQ == S_CALC) || (stateQ == S_END);
  end

  // datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      divisorQ  <= '0;
      remQ      <= '0;
      quotQ     <= '0;
      cntQ      <= '0;
      wAddrQ    <= '0;
      isRemQ    <= 1'b0;
      negQuotQ  <= 1'b0;
      negRemQ   <= 1'b0;
      resultOut <= '0;
      readyOut  <= 1'b0;
      wAddrOut  <= '0;
    end else begin
      readyOut <= 1'b0;
      case (stateQ)
        S_IDLE: begin
          if (launch) begin
            isRemQ   <= opIn[1];
            wAddrQ   <= wAddrIn;
            negQuotQ <= signedOp && (dividendIn[DATA_W-1] ^ divisorIn[DATA_W-1]);
            negRemQ  <= signedOp && dividendIn[DATA_W-1];
            if (special) begin
              resultOut <= specialResult;
              readyOut  <= 1'b1;
              wAddrOut  <= wAddrIn;
            end else begin
              divisorQ <= absDivisor;
              quotQ    <= absDividend;
              remQ     <= '0;
              cntQ     <= '0;
            end
          end
        end
        S_CALC: begin
          if (!flushIn) begin
            remQ  <= remGe ? remDiff[DATA_W-1:0] : remShift[DATA_W-1:0];
            quotQ <= {quotQ[DATA_W-2:0], remGe};
            cntQ  <= cntQ + CNT_W'(1);
          end
        end
        S_END: begin
          if (!flushIn) begin
            resultOut <= finalResult;
            readyOut  <= 1'b1;
            wAddrOut  <= wAddrQ;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed cases plus random operations
// checked against an arithmetic reference of the RV32M divide rules.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startIn = 1'b0;
  logic [1:0]  opIn = 2'd0;
  logic [31:0] dividendIn = '0;
  logic [31:0] divisorIn = '0;
  logic [4:0]  wAddrIn = '0;
  logic        flushIn = 1'b0;
  logic [31:0] resultOut;
  logic        readyOut;
  logic [4:0]  wAddrOut;
  logic        busyOut;
  logic        holdOut;

  int checks = 0;
  int errors = 0;

  ex_div #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .startIn(startIn), .opIn(opIn),
    .dividendIn(dividendIn), .divisorIn(divisorIn), .wAddrIn(wAddrIn),
    .flushIn(flushIn), .resultOut(resultOut), .readyOut(readyOut),
    .wAddrOut(wAddrOut), .busyOut(busyOut), .holdOut(holdOut)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic isSpecial(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'd0:    return ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      2'd1:    return a / b;
      2'd2:    return ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  // Launch in the current cycle N, follow to the readyOut pulse, check
  // latency, result, destination, stall profile and the pulse width.
  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wa);
    int lat;
    int holdBad;
    logic sp;
    logic [31:0] exp;
    sp  = isSpecial(op, a, b);
    exp = refResult(op, a, b);
    opIn = op; dividendIn = a; divisorIn = b; wAddrIn = wa; startIn = 1'b1;
    #1;
    holdBad = (holdOut !== !sp) ? 1 : 0;
    tick();
    startIn = 1'b0;
    opIn = 2'($urandom); dividendIn = $urandom; divisorIn = $urandom; wAddrIn = 5'($urandom);
    lat = 1;
    while (readyOut !== 1'b1 && lat < 40) begin
      if (holdOut !== 1'b1) holdBad++;
      tick();
      lat++;
    end
    if (holdOut !== 1'b0) holdBad++;
    checkVal({tag, " latency"}, 32'(lat), sp ? 32'd1 : 32'd34);
    checkVal({tag, " result"}, resultOut, exp);
    checkVal({tag, " wAddr"}, 32'(wAddrOut), 32'(wa));
    checkVal({tag, " holdProfile"}, 32'(holdBad), 32'd0);
    tick();
    checkVal({tag, " readyPulse"}, 32'(readyOut), 32'd0);
  endtask

  initial begin
    int readyCnt;
    int lat;
    logic [31:0] got;
    logic [4:0] gotW;
    logic [31:0] prevRes;
    logic [1:0] op;
    logic [31:0] a, b;

    tick(); tick();
    rst = 1'b0;
    checkVal("reset result", resultOut, 32'd0);
    checkVal("reset ready", 32'(readyOut), 32'd0);
    checkVal("reset wAddr", 32'(wAddrOut), 32'd0);
    checkVal("reset busy", 32'(busyOut), 32'd0);
    checkVal("reset hold", 32'(holdOut), 32'd0);

    runOp("DIVU 100/7", 2'd1, 32'd100, 32'd7, 5'd11);
    runOp("DIV -7/2", 2'd0, 32'hFFFF_FFF9, 32'd2, 5'd3);
    runOp("REM -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 5'd4);
    runOp("REM 7/-2", 2'd2, 32'd7, 32'hFFFF_FFFE, 5'd5);
    runOp("REMU ffffffff/16", 2'd3, 32'hFFFF_FFFF, 32'd16, 5'd6);
    runOp("DIV x/0", 2'd0, 32'd1234, 32'd0, 5'd7);
    runOp("REMU 123/0", 2'd3, 32'd123, 32'd0, 5'd8);
    runOp("DIV ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    runOp("REM ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    runOp("DIVU max/1", 2'd1, 32'hFFFF_FFFF, 32'd1, 5'd12);
    runOp("DIV min/1", 2'd0, 32'h8000_0000, 32'd1, 5'd13);

    // flush takes priority over a start in IDLE
    opIn = 2'd1; dividendIn = 32'd50; divisorIn = 32'd5; startIn = 1'b1; flushIn = 1'b1;
    tick();
    startIn = 1'b0; flushIn = 1'b0;
    checkVal("flushIdle busy", 32'(busyOut), 32'd0);
    checkVal("flushIdle ready", 32'(readyOut), 32'd0);

    // flush mid-calculation at N+10, relaunch at N+12
    prevRes = resultOut;
    opIn = 2'd1; dividendIn = 32'd500; divisorIn = 32'd3; wAddrIn = 5'd20; startIn = 1'b1;
    tick();
    startIn = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    flushIn = 1'b1;
    tick();
    flushIn = 1'b0;
    checkVal("flush busy", 32'(busyOut), 32'd0);
    checkVal("flush ready", 32'(readyOut), 32'd0);
    checkVal("flush result", resultOut, prevRes);
    tick();
    runOp("DIVU 9/3 after flush", 2'd1, 32'd9, 32'd3, 5'd21);

    // start pulsed while busy is ignored
    opIn = 2'd1; dividendIn = 32'd1000; divisorIn = 32'd7; wAddrIn = 5'd5; startIn = 1'b1;
    tick();
    readyCnt = 0; lat = 0; got = '0; gotW = '0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      if (cyc == 5) begin
        startIn = 1'b1; opIn = 2'd0; dividendIn = 32'd55; divisorIn = 32'd0; wAddrIn = 5'd9;
      end else begin
        startIn = 1'b0;
      end
      if (readyOut === 1'b1) begin
        readyCnt++;
        if (lat == 0) begin
          lat = cyc; got = resultOut; gotW = wAddrOut;
        end
      end
      tick();
    end
    startIn = 1'b0;
    checkVal("busyStart pulses", 32'(readyCnt), 32'd1);
    checkVal("busyStart latency", 32'(lat), 32'd34);
    checkVal("busyStart result", got, 32'd142);
    checkVal("busyStart wAddr", 32'(gotW), 32'd5);

    // reset mid-operation at N+20
    opIn = 2'd0; dividendIn = 32'd77; divisorIn = 32'd4; wAddrIn = 5'd17; startIn = 1'b1;
    tick();
    startIn = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkVal("midReset result", resultOut, 32'd0);
    checkVal("midReset ready", 32'(readyOut), 32'd0);
    checkVal("midReset wAddr", 32'(wAddrOut), 32'd0);
    checkVal("midReset busy", 32'(busyOut), 32'd0);
    readyCnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (readyOut === 1'b1) readyCnt++;
      tick();
    end
    checkVal("midReset noReady", 32'(readyCnt), 32'd0);
    runOp("DIV after reset", 2'd0, 32'd77, 32'hFFFF_FFFC, 5'd18);

    // random operations
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = $urandom >> $urandom_range(0, 31);
        4: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      runOp($sformatf("rand%0d op%0d", n, op), op, a, b, 5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
